// File: rtl/bank_req_responder.sv
`default_nettype none
// ============================================================================
// Module   : bank_req_responder
// Brief    : Back-end stand-in for front_end bring-up. Round-robin accepts one
//            per-bank request per cycle, models a fixed-latency memory access
//            through an LAT-deep pipeline and returns in-order completions
//            through a credit-limited response FIFO and a registered output.
// Revision : 1.0 - initial release
// ============================================================================
module bank_req_responder #(
    parameter int NB        = 16,
    parameter int DQ        = 16,
    parameter int IDX       = 7,
    parameter int RA        = 16,
    parameter int CA        = 10,
    parameter int CW        = 4,
    parameter int DOUT      = 32,
    parameter int LAT       = 4,
    parameter int RSP_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NB-1:0]     valid_i,
    output logic [NB-1:0]     ready_o,
    input  logic [NB*DQ-1:0]  dq_i,
    input  logic [NB*IDX-1:0] idx_i,
    input  logic [NB*RA-1:0]  ra_i,
    input  logic [NB*CA-1:0]  ca_i,
    input  logic [NB-1:0]     t_i,
    input  logic              rsp_busy,
    output logic              request_done_valid,
    output logic              the_type,
    output logic [DOUT-1:0]   data_in,
    output logic [IDX-1:0]    index
);

    localparam int c_bank_w  = $clog2(NB);
    localparam int c_addr_w  = c_bank_w + CW;
    localparam int c_words   = NB * (2 ** CW);
    localparam int c_cnt_w   = $clog2(RSP_DEPTH + 1);
    localparam int c_ptr_w   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic c_read  = 1'b1;
    localparam logic c_write = 1'b0;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(RSP_DEPTH);
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(RSP_DEPTH - 1);

    // Arbitration / credit state
    logic [c_bank_w-1:0] r_rr_ptr;
    logic [c_cnt_w-1:0]  r_outstanding;

    // Access pipeline (index 0 = stage 1, index LAT-1 = exit stage)
    logic                r_pv    [LAT];
    logic [c_bank_w-1:0] r_pbank [LAT];
    logic                r_pt    [LAT];
    logic [DQ-1:0]       r_pdq   [LAT];
    logic [IDX-1:0]      r_pidx  [LAT];
    logic [CW-1:0]       r_pca   [LAT];

    // Storage (intentionally not reset)
    logic [DQ-1:0]       r_mem   [c_words];

    // Response FIFO
    logic                r_f_type [RSP_DEPTH];
    logic [DQ-1:0]       r_f_data [RSP_DEPTH];
    logic [IDX-1:0]      r_f_idx  [RSP_DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_fcnt;

    // Registered completion port
    logic                r_out_v;
    logic                r_out_type;
    logic [DOUT-1:0]     r_out_data;
    logic [IDX-1:0]      r_out_idx;

    logic [NB-1:0]       w_grant;
    logic [c_bank_w-1:0] w_gnt_bank;
    logic [c_bank_w-1:0] w_cand;
    logic                w_found;
    logic                w_accept;
    logic                w_exit_v;
    logic [c_addr_w-1:0] w_exit_addr;
    logic [DQ-1:0]       w_push_data;
    logic                w_load;
    logic                w_pop;
    logic                w_unused;

    // Row address is accepted but not modelled; upper column bits are ignored
    assign w_unused = ^{ra_i, ca_i};

    // Round-robin search from r_rr_ptr; grant only when a credit is free
    always_comb begin
        w_grant    = '0;
        w_gnt_bank = '0;
        w_cand     = '0;
        w_found    = 1'b0;
        for (int i = 0; i < NB; i++) begin
            w_cand = r_rr_ptr + c_bank_w'(i);
            if (!w_found && valid_i[w_cand]) begin
                w_found    = 1'b1;
                w_gnt_bank = w_cand;
            end
        end
        if (w_found && !rst && (r_outstanding < c_depth)) begin
            w_grant[w_gnt_bank] = 1'b1;
        end
    end

    assign ready_o  = w_grant;
    assign w_accept = |w_grant;

    // Exit stage: writes update storage, reads sample it in acceptance order
    assign w_exit_v    = r_pv[LAT-1];
    assign w_exit_addr = {r_pbank[LAT-1], r_pca[LAT-1]};
    assign w_push_data = (r_pt[LAT-1] == c_read) ? r_mem[w_exit_addr] : '0;

    // Output register refills from the FIFO head when empty or being consumed
    assign w_pop  = r_out_v && !rsp_busy;
    assign w_load = (!r_out_v || !rsp_busy) && (r_fcnt != '0);

    // Round-robin pointer advances past the granted bank on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= w_gnt_bank + 1'b1;
        end
    end

    // Outstanding credit count: +1 on accept, -1 on completion pop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outstanding <= '0;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Pipeline valid bits; reset flushes all in-flight work
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                r_pv[i] <= 1'b0;
            end
        end else begin
            r_pv[0] <= w_accept;
            for (int i = 1; i < LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
            end
        end
    end

    // Pipeline payload shifts every cycle; qualified by r_pv
    always_ff @(posedge clk) begin
        r_pbank[0] <= w_gnt_bank;
        r_pt[0]    <= t_i[w_gnt_bank];
        r_pdq[0]   <= dq_i[int'(w_gnt_bank)*DQ +: DQ];
        r_pidx[0]  <= idx_i[int'(w_gnt_bank)*IDX +: IDX];
        r_pca[0]   <= ca_i[int'(w_gnt_bank)*CA +: CW];
        for (int i = 1; i < LAT; i++) begin
            r_pbank[i] <= r_pbank[i-1];
            r_pt[i]    <= r_pt[i-1];
            r_pdq[i]   <= r_pdq[i-1];
            r_pidx[i]  <= r_pidx[i-1];
            r_pca[i]   <= r_pca[i-1];
        end
    end

    // Storage write for a WRITE leaving the pipeline
    always_ff @(posedge clk) begin
        if (!rst && w_exit_v && (r_pt[LAT-1] == c_write)) begin
            r_mem[w_exit_addr] <= r_pdq[LAT-1];
        end
    end

    // FIFO payload write on every pipeline exit
    always_ff @(posedge clk) begin
        if (!rst && w_exit_v) begin
            r_f_type[r_wr_ptr] <= r_pt[LAT-1];
            r_f_data[r_wr_ptr] <= w_push_data;
            r_f_idx[r_wr_ptr]  <= r_pidx[LAT-1];
        end
    end

    // FIFO pointers and occupancy; credits guarantee no overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fcnt   <= '0;
        end else begin
            if (w_exit_v) begin
                r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_load) begin
                r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_exit_v, w_load})
                2'b10:   r_fcnt <= r_fcnt + 1'b1;
                2'b01:   r_fcnt <= r_fcnt - 1'b1;
                default: r_fcnt <= r_fcnt;
            endcase
        end
    end

    // Completion register: load head, hold while busy, drop valid after pop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_v    <= 1'b0;
            r_out_type <= 1'b0;
            r_out_data <= '0;
            r_out_idx  <= '0;
        end else if (w_load) begin
            r_out_v    <= 1'b1;
            r_out_type <= r_f_type[r_rd_ptr];
            r_out_data <= DOUT'(r_f_data[r_rd_ptr]);
            r_out_idx  <= r_f_idx[r_rd_ptr];
        end else if (w_pop) begin
            r_out_v    <= 1'b0;
        end
    end

    assign request_done_valid = r_out_v;
    assign the_type           = r_out_type;
    assign data_in            = r_out_data;
    assign index              = r_out_idx;

endmodule
`default_nettype wire
